// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// control bit positions, FSM state encoding and the bit-length helper.
package uart_tx_dev_pkg;

   // Register select values on Addr[3:2] (port bits [1:0] of the word address)
   localparam logic [1:0] UART_REG_DATA   = 2'd0;
   localparam logic [1:0] UART_REG_STATUS = 2'd1;
   localparam logic [1:0] UART_REG_CTRL   = 2'd2;
   localparam logic [1:0] UART_REG_DIV    = 2'd3;

   // CTRL bit indices
   localparam int UART_CTRL_TX_EN  = 0;
   localparam int UART_CTRL_IRQ_EN = 1;

   // Transmit FSM encoding
   localparam int UART_ST_LEN = 2;
   typedef enum logic [UART_ST_LEN-1:0] {
      UART_ST_IDLE  = 2'd0,
      UART_ST_START = 2'd1,
      UART_ST_DATA  = 2'd2,
      UART_ST_STOP  = 2'd3
   } uart_state_t;

   // Clocks per bit for a DIVISOR value; zero is treated as one
   function automatic logic [15:0] bit_cycles(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART transmitter. Push into a full FIFO is dropped;
// the full test uses the occupancy before any simultaneous pop.
module uart_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally (power-of-two depth); count tracks occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read after being written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter. Software pushes bytes via DATA, they are
// queued in a small FIFO and shifted out LSB first at DIVISOR clocks per bit.
// IRQ is a level request asserted while enabled and the transmitter is drained.
module uart_tx_dev #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        tx
);

   import uart_tx_dev_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]    sel;
   logic [1:0]    ctrl;
   logic [15:0]   divisor;
   logic          push;
   logic          pop;
   logic [7:0]    head;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          busy;
   logic          tx_en;
   logic [15:0]   bit_load;

   uart_state_t   state, state_n;
   logic [15:0]   cyc, cyc_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, shreg_n;
   logic          tx_n;

   // Only the register select is decoded; the rest of the bus is ignored
   logic          unused_bus;
   assign unused_bus = ^{Addr[29:2], Din[31:16]};

   assign sel      = Addr[1:0];
   assign tx_en    = ctrl[UART_CTRL_TX_EN];
   assign push     = WE && (sel == UART_REG_DATA);
   assign busy     = (state != UART_ST_IDLE);
   assign IRQ      = ctrl[UART_CTRL_IRQ_EN] & empty & ~busy;
   // Bit length is sampled from DIVISOR at each bit boundary, so a write
   // mid-frame only affects the bits that start after it
   assign bit_load = bit_cycles(divisor) - 16'd1;

   uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (Din[7:0]),
      .head  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   // CTRL and DIVISOR software-writable registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl    <= 2'b00;
         divisor <= DIV_RESET;
      end else if (WE) begin
         if (sel == UART_REG_CTRL) ctrl    <= Din[1:0];
         if (sel == UART_REG_DIV)  divisor <= Din[15:0];
      end
   end

   // Transmit FSM state and line register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= UART_ST_IDLE;
         cyc     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_n;
         cyc     <= cyc_n;
         bit_idx <= bit_n;
         shreg   <= shreg_n;
         tx      <= tx_n;
      end
   end

   // Next-state, baud countdown and FIFO pop; cyc counts remaining cycles of
   // the current bit minus one
   always_comb begin
      state_n = state;
      cyc_n   = cyc;
      bit_n   = bit_idx;
      shreg_n = shreg;
      pop     = 1'b0;
      unique case (state)
         UART_ST_IDLE: begin
            if (tx_en && !empty) begin
               pop     = 1'b1;
               shreg_n = head;
               cyc_n   = bit_load;
               state_n = UART_ST_START;
            end
         end
         UART_ST_START: begin
            if (cyc == 16'd0) begin
               state_n = UART_ST_DATA;
               bit_n   = 3'd0;
               cyc_n   = bit_load;
            end else begin
               cyc_n = cyc - 16'd1;
            end
         end
         UART_ST_DATA: begin
            if (cyc == 16'd0) begin
               cyc_n = bit_load;
               if (bit_idx == 3'd7) begin
                  state_n = UART_ST_STOP;
               end else begin
                  bit_n   = bit_idx + 3'd1;
                  shreg_n = {1'b0, shreg[7:1]};
               end
            end else begin
               cyc_n = cyc - 16'd1;
            end
         end
         UART_ST_STOP: begin
            if (cyc == 16'd0) begin
               // Back-to-back frames: go straight to START without idling
               if (tx_en && !empty) begin
                  pop     = 1'b1;
                  shreg_n = head;
                  cyc_n   = bit_load;
                  state_n = UART_ST_START;
               end else begin
                  state_n = UART_ST_IDLE;
               end
            end else begin
               cyc_n = cyc - 16'd1;
            end
         end
         default: state_n = UART_ST_IDLE;
      endcase

      // Line level is registered from the next state to keep tx glitch-free
      unique case (state_n)
         UART_ST_START: tx_n = 1'b0;
         UART_ST_DATA:  tx_n = shreg_n[0];
         default:       tx_n = 1'b1;
      endcase
   end

   // Read mux, combinational from the register select
   always_comb begin
      Dout = 32'd0;
      unique case (sel)
         UART_REG_DATA:   Dout = 32'd0;
         UART_REG_STATUS: Dout = {24'd0, IRQ, busy, full, empty, 4'(count)};
         UART_REG_CTRL:   Dout = {30'd0, ctrl};
         UART_REG_DIV:    Dout = {16'd0, divisor};
         default:         Dout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: directed scenarios plus a randomized
// run, all compared against a frame-level reference model.
module tb_uart_tx_dev;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        tx;

   always #5 clk = ~clk;

   uart_tx_dev #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd16)) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ),
      .tx    (tx)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   byte unsigned m_q[$];
   logic [1:0]   m_ctrl;
   logic [15:0]  m_div;
   bit           m_busy;
   logic [9:0]   m_frame;   // [0]=start, [8:1]=data LSB first, [9]=stop
   int           m_pos;
   int           m_left;    // cycles left in current bit, including this one

   function automatic int m_eff(input logic [15:0] d);
      return (d == 16'd0) ? 1 : int'(d);
   endfunction

   function automatic logic m_tx();
      return m_busy ? m_frame[m_pos] : 1'b1;
   endfunction

   function automatic logic m_irq();
      return m_ctrl[1] && (m_q.size() == 0) && !m_busy;
   endfunction

   function automatic logic [31:0] m_status();
      logic e, f;
      e = (m_q.size() == 0);
      f = (m_q.size() == DEPTH);
      return {24'd0, m_irq(), m_busy, f, e, 4'(m_q.size())};
   endfunction

   function automatic logic [31:0] m_dout(input logic [1:0] a);
      case (a)
         2'd1:    return m_status();
         2'd2:    return {30'd0, m_ctrl};
         2'd3:    return {16'd0, m_div};
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_ctrl  = 2'b00;
      m_div   = 16'd16;
      m_busy  = 1'b0;
      m_pos   = 0;
      m_left  = 0;
      m_frame = '1;
   endtask

   task automatic m_start();
      byte unsigned b;
      b       = m_q.pop_front();
      m_frame = {1'b1, b, 1'b0};
      m_pos   = 0;
      m_left  = m_eff(m_div);
      m_busy  = 1'b1;
   endtask

   // One clock edge with the given bus inputs
   task automatic m_step(input bit we, input logic [1:0] a, input logic [31:0] d);
      bit was_full;
      was_full = (m_q.size() == DEPTH);
      if (!m_busy) begin
         if (m_ctrl[0] && m_q.size() > 0) m_start();
      end else if (m_left > 1) begin
         m_left--;
      end else if (m_pos < 9) begin
         m_pos++;
         m_left = m_eff(m_div);
      end else begin
         m_busy = 1'b0;
         if (m_ctrl[0] && m_q.size() > 0) m_start();
      end
      if (we) begin
         if (a == 2'd0 && !was_full) m_q.push_back(d[7:0]);
         if (a == 2'd2) m_ctrl = d[1:0];
         if (a == 2'd3) m_div  = d[15:0];
      end
   endtask

   // ---------------- bus cycle ----------------
   logic [31:0]  rd;
   logic         last_tx;
   logic [255:0] wave;

   task automatic tick(input bit we, input logic [1:0] a, input logic [31:0] d);
      WE   = we;
      Addr = {28'd0, a};
      Din  = d;
      @(negedge clk);
      last_tx = tx;
      check("tx", tx, m_tx());
      check("irq", IRQ, m_irq());
      if (!we) begin
         rd = Dout;
         check("dout", Dout, m_dout(a));
      end
      @(posedge clk);
      m_step(we, a, d);
      #1;
   endtask

   // Read STATUS until a busy period has been seen and ended
   task automatic wait_idle(output int n);
      bit seen;
      bit done;
      n    = 0;
      seen = 0;
      done = 0;
      wave = '0;
      for (int i = 0; i < 2000 && !done; i++) begin
         tick(1'b0, 2'd1, 32'd0);
         if (rd[6]) begin
            if (n < 256) wave[n] = last_tx;
            n++;
            seen = 1;
         end else if (seen) begin
            done = 1;
         end
      end
      if (!done) check("wait_idle_timeout", 0, 1);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      WE   = 1'b0;
      Addr = 30'd1;
      #1;
      m_reset();
      check("rst_tx", tx, 1'b1);
      check("rst_irq", IRQ, 1'b0);
      check("rst_status", Dout, 32'h10);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [63:0] exp;
      logic [7:0]  a5;
      bit          done;

      reset = 1'b1;
      WE    = 1'b0;
      Addr  = 30'd1;
      Din   = 32'd0;
      m_reset();
      #3;
      check("reset_tx", tx, 1'b1);
      check("reset_irq", IRQ, 1'b0);
      check("reset_status", Dout, 32'h10);
      Addr = 30'd3;
      #1 check("reset_div", Dout, 32'd16);
      Addr = 30'd2;
      #1 check("reset_ctrl", Dout, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Single frame 0xA5 at 4 clocks per bit
      tick(1'b1, 2'd3, 32'd4);
      tick(1'b1, 2'd2, 32'd1);
      tick(1'b1, 2'd0, 32'hA5);
      wait_idle(n);
      check("a5_busy", n, 40);
      a5  = 8'hA5;
      exp = '0;
      for (int i = 0; i < 40; i++) begin
         if (i < 4)       exp[i] = 1'b0;
         else if (i < 36) exp[i] = a5[(i - 4) / 4];
         else             exp[i] = 1'b1;
      end
      check("a5_wave", {24'd0, wave[39:0]}, exp);
      check("a5_status", rd, 32'h10);

      // Fill with TX disabled, fifth push dropped, then four back-to-back frames
      tick(1'b1, 2'd2, 32'd0);
      tick(1'b1, 2'd0, 32'h11);
      tick(1'b1, 2'd0, 32'h22);
      tick(1'b1, 2'd0, 32'h33);
      tick(1'b1, 2'd0, 32'h44);
      tick(1'b1, 2'd0, 32'h55);
      tick(1'b0, 2'd1, 32'd0);
      check("full_status", rd, 32'h24);
      tick(1'b1, 2'd2, 32'd1);
      wait_idle(n);
      check("b2b_busy", n, 160);

      // IRQ behaviour
      tick(1'b1, 2'd2, 32'd3);
      check("irq_idle", IRQ, 1'b1);
      tick(1'b1, 2'd0, 32'h3C);
      check("irq_push", IRQ, 1'b0);
      wait_idle(n);
      check("irq_done", IRQ, 1'b1);
      tick(1'b1, 2'd2, 32'd1);
      check("irq_clr", IRQ, 1'b0);

      // DIVISOR 4 -> 8 written during data bit 2
      tick(1'b1, 2'd0, 32'h5A);
      n    = 0;
      done = 0;
      for (int i = 0; i < 500 && !done; i++) begin
         if (n == 14) begin
            tick(1'b1, 2'd3, 32'd8);
            n++;
         end else begin
            tick(1'b0, 2'd1, 32'd0);
            if (rd[6]) n++;
            else if (n > 0) done = 1;
         end
      end
      if (!done) check("div_timeout", 0, 1);
      check("div_busy", n, 64);

      // Reset during data bit 5 with two bytes queued
      tick(1'b1, 2'd3, 32'd4);
      tick(1'b1, 2'd0, 32'h0F);
      tick(1'b1, 2'd0, 32'h22);
      tick(1'b1, 2'd0, 32'h33);
      n = 0;
      for (int i = 0; i < 200 && n < 26; i++) begin
         tick(1'b0, 2'd1, 32'd0);
         if (rd[6]) n++;
      end
      check("pre_rst_busy", n, 26);
      check("pre_rst_tx", tx, 1'b0);
      do_reset();
      tick(1'b1, 2'd2, 32'd1);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1'b0, 2'd1, 32'd0);
         if (rd[6]) n++;
      end
      check("post_rst_busy", n, 0);
      check("post_rst_status", rd, 32'h10);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int unsigned r;
         r = $urandom_range(0, 999);
         if (r < 600)
            tick(1'b0, 2'($urandom_range(0, 3)), 32'd0);
         else if (r < 780)
            tick(1'b1, 2'd0, $urandom);
         else if (r < 860)
            tick(1'b1, 2'd2, {$urandom_range(0, 65535), 14'd0, 2'($urandom_range(0, 3))});
         else if (r < 920)
            tick(1'b1, 2'd3, {16'($urandom), 16'($urandom_range(0, 3))});
         else if (r < 995)
            tick(1'b1, 2'd1, $urandom);
         else
            do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
